// File: rtl/cnn_layer_accel_result_packer_if.sv
// Result-stream and packed-word-stream signals of the CNN result packer.
// master: the packer side; slave: the quad/memory-path side.
interface cnn_layer_accel_result_packer_if;
  logic         result_valid;
  logic         result_accept;
  logic [15:0]  result_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_keep;
  logic         out_last;

  modport master (
    input  result_valid, result_data, out_ready,
    output result_accept, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    output result_valid, result_data, out_ready,
    input  result_accept, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's 16-bit result stream into 8-lane 128-bit words (closed at row end) behind a 2-entry FIFO.
// Build option CNN_RESULT_PACKER_RELU_EN clamps negative results to zero before packing.
module cnn_layer_accel_result_packer (
  input  logic                            clk_core,
  input  logic                            rst,
  input  logic                            start,
  input  logic [9:0]                      num_output_rows_cfg,
  input  logic [9:0]                      num_output_cols_cfg,
  input  logic [6:0]                      num_kernel_cfg,
  cnn_layer_accel_result_packer_if.master rp,
  output logic [9:0]                      output_row,
  output logic [9:0]                      output_col,
  output logic [6:0]                      output_depth,
  output logic                            busy,
  output logic                            done
);

  localparam int LANES  = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [9:0]               rows_q, cols_q;
  logic [6:0]               kern_q;
  logic [2:0]               lane_idx;
  logic [7:0]               keep_acc;
  logic signed [DATA_W-1:0] lane_q [LANES];

  logic [127:0] fifo_data [2];
  logic [7:0]   fifo_keep [2];
  logic         fifo_last [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   fifo_count;

  logic                     cfg_ok, start_go, take, push, pop;
  logic                     last_col, last_row, last_depth, final_res;
  logic signed [DATA_W-1:0] res_val;
  logic [127:0]             word_nxt;
  logic [7:0]               keep_nxt;
  logic                     done_nxt;

  function automatic logic signed [DATA_W-1:0] relu_f(input logic signed [DATA_W-1:0] v);
`ifdef CNN_RESULT_PACKER_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign cfg_ok     = (|num_output_rows_cfg) && (|num_output_cols_cfg) && (|num_kernel_cfg);
  assign start_go   = (state == IDLE) && start && cfg_ok;
  assign take       = rp.result_valid && rp.result_accept;
  assign last_col   = (output_col == cols_q - 10'd1);
  assign last_row   = (output_row == rows_q - 10'd1);
  assign last_depth = (output_depth == kern_q - 7'd1);
  assign final_res  = last_col && last_row && last_depth;
  assign push       = take && ((lane_idx == 3'd7) || last_col);
  assign pop        = rp.out_valid && rp.out_ready;
  assign res_val    = relu_f(signed'(rp.result_data));

  // Full accept is gated off here, so a push never meets a full FIFO.
  assign rp.result_accept = (state == RUN) && (fifo_count != 2'd2);
  assign rp.out_valid     = (fifo_count != 2'd0);
  assign rp.out_data      = rp.out_valid ? fifo_data[rd_ptr] : '0;
  assign rp.out_keep      = rp.out_valid ? fifo_keep[rd_ptr] : '0;
  assign rp.out_last      = rp.out_valid ? fifo_last[rd_ptr] : 1'b0;
  assign busy             = (state != IDLE);

  always_comb begin
    word_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) == lane_idx) word_nxt[DATA_W*i +: DATA_W] = res_val;
      else                   word_nxt[DATA_W*i +: DATA_W] = lane_q[i];
    end
    keep_nxt = keep_acc | (8'd1 << lane_idx);
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_ok) state_nxt = RUN;
        else if (start)      done_nxt  = 1'b1;
      end
      RUN: begin
        if (take && final_res) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the last buffered word is leaving, so done follows its pop by one cycle.
        if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      output_row   <= '0;
      output_col   <= '0;
      output_depth <= '0;
      lane_idx     <= '0;
      keep_acc     <= '0;
    end else if (start_go) begin
      output_row   <= '0;
      output_col   <= '0;
      output_depth <= '0;
      lane_idx     <= '0;
      keep_acc     <= '0;
    end else if (take) begin
      if (last_col) begin
        output_col <= '0;
        if (last_row) begin
          output_row   <= '0;
          output_depth <= output_depth + 7'd1;
        end else begin
          output_row <= output_row + 10'd1;
        end
      end else begin
        output_col <= output_col + 10'd1;
      end
      if (push) begin
        lane_idx <= '0;
        keep_acc <= '0;
      end else begin
        lane_idx <= lane_idx + 3'd1;
        keep_acc <= keep_nxt;
      end
    end
  end

  // Lane staging and job counts: zeroed/loaded on start, so unused lanes of a closed word read as zero.
  always_ff @(posedge clk_core) begin
    if (start_go) begin
      rows_q <= num_output_rows_cfg;
      cols_q <= num_output_cols_cfg;
      kern_q <= num_kernel_cfg;
    end
    if (start_go || push) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else if (take) begin
      lane_q[lane_idx] <= res_val;
    end
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (push) begin
      fifo_data[wr_ptr] <= word_nxt;
      fifo_keep[wr_ptr] <= keep_nxt;
      fifo_last[wr_ptr] <= final_res;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Scoreboard bench for cnn_layer_accel_result_packer: stimulus queues expected words, a monitor checks pops.
module tb_cnn_layer_accel_result_packer;

  logic       clk_core = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] rows_cfg, cols_cfg;
  logic [6:0] kern_cfg;
  logic [9:0] output_row, output_col;
  logic [6:0] output_depth;
  logic       busy, done;

  always #5 clk_core = ~clk_core;

  cnn_layer_accel_result_packer_if ifc ();

  cnn_layer_accel_result_packer dut (
    .clk_core            (clk_core),
    .rst                 (rst),
    .start               (start),
    .num_output_rows_cfg (rows_cfg),
    .num_output_cols_cfg (cols_cfg),
    .num_kernel_cfg      (kern_cfg),
    .rp                  (ifc.master),
    .output_row          (output_row),
    .output_col          (output_col),
    .output_depth        (output_depth),
    .busy                (busy),
    .done                (done)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   k;
    logic         l;
  } word_t;

  word_t exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each popped word with the scoreboard head and checks handshake rules.
  logic         done_due = 1'b0;
  logic         hold_prev = 1'b0;
  logic [127:0] hold_d = '0;
  word_t        w_mon;

  always @(negedge clk_core) begin
    if (rst) begin
      done_due  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (done_due) begin
        chk("done_after_last_pop", done, 1);
        done_due = 1'b0;
      end
      if (hold_prev) begin
        chk("valid_held", ifc.out_valid, 1);
        chk("data_held", ifc.out_data, hold_d);
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", ifc.out_data);
        end else begin
          w_mon = exp_q.pop_front();
          chk("word_data", ifc.out_data, w_mon.d);
          chk("word_keep", ifc.out_keep, w_mon.k);
          chk("word_last", ifc.out_last, w_mon.l);
          if (ifc.out_last) done_due = 1'b1;
        end
      end
      hold_prev = ifc.out_valid && !ifc.out_ready;
      hold_d    = ifc.out_data;
    end
  end

  task automatic do_start(input logic [9:0] r, input logic [9:0] c, input logic [6:0] k);
    @(posedge clk_core); #1;
    rows_cfg = r;
    cols_cfg = c;
    kern_cfg = k;
    start    = 1'b1;
    @(posedge clk_core); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v);
    bit got = 1'b0;
    ifc.result_valid = 1'b1;
    ifc.result_data  = v;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk_core);
      if (ifc.result_accept) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: got no accept expected accept for %0h", v);
    end else begin
      @(posedge clk_core); #1;
      acc_cnt++;
    end
    ifc.result_valid = 1'b0;
  endtask

  // Reference packing: column-major per row, word closed at 8 lanes or row end.
  task automatic expect_job(input int r, input int c, input int k, input logic [15:0] base);
    int    idx = 0;
    int    lane;
    word_t w;
    for (int d = 0; d < k; d++) begin
      for (int rr = 0; rr < r; rr++) begin
        w = '0;
        lane = 0;
        for (int cc = 0; cc < c; cc++) begin
          w.d[16*lane +: 16] = 16'(base + idx);
          w.k[lane] = 1'b1;
          idx++;
          lane++;
          if (lane == 8 || cc == c - 1) begin
            w.l = (d == k - 1) && (rr == r - 1) && (cc == c - 1);
            exp_q.push_back(w);
            w = '0;
            lane = 0;
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 300 && done_cnt < target; n++) @(posedge clk_core);
    chk("done_count", done_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int    d0;
    int    a0;
    word_t w;
    rst = 1'b1;
    start = 1'b0;
    rows_cfg = '0;
    cols_cfg = '0;
    kern_cfg = '0;
    ifc.result_valid = 1'b0;
    ifc.result_data  = '0;
    ifc.out_ready    = 1'b1;
    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
    chk("rst_accept", ifc.result_accept, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_data", ifc.out_data, 0);
    chk("rst_keep_last", {ifc.out_keep, ifc.out_last}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_position", {output_row, output_col, output_depth}, 0);
    @(posedge clk_core); #1;
    rst = 1'b0;

    // Single full word 1..8
    w = '{d: 128'h0008_0007_0006_0005_0004_0003_0002_0001, k: 8'hFF, l: 1'b1};
    exp_q.push_back(w);
    do_start(10'd1, 10'd8, 7'd1);
    chk("accept_after_start", ifc.result_accept, 1);
    chk("busy_after_start", busy, 1);
    for (int i = 1; i <= 8; i++) feed(16'(i));
    wait_done(1);
    chk("depth_after_job", output_depth, 1);
    chk("idle_after_job", busy, 0);

    // Two rows of 10: full/partial words per row
    expect_job(2, 10, 1, 16'h0100);
    do_start(10'd2, 10'd10, 7'd1);
    for (int i = 0; i < 20; i++) begin
      feed(16'(16'h0100 + i));
      if (i == 11) chk("position_mid_row", {output_row, output_col}, {10'd1, 10'd2});
    end
    wait_done(2);

    // Back-pressure: FIFO fills after two words, then drains in order
    ifc.out_ready = 1'b0;
    expect_job(1, 24, 1, 16'h0200);
    do_start(10'd1, 10'd24, 7'd1);
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 24; i++) feed(16'(16'h0200 + i));
      end
      begin
        repeat (30) @(posedge clk_core);
        @(negedge clk_core);
        chk("accepted_while_stalled", acc_cnt - a0, 16);
        chk("accept_low_when_full", ifc.result_accept, 0);
        @(posedge clk_core); #1;
        ifc.out_ready = 1'b1;
      end
    join
    wait_done(3);

    // Sign-bit results (clamped only in the ReLU build)
`ifdef CNN_RESULT_PACKER_RELU_EN
    w = '{d: {80'h0, 16'h7FFF, 16'h0000, 16'h0000}, k: 8'h07, l: 1'b1};
`else
    w = '{d: {80'h0, 16'h7FFF, 16'h8000, 16'hFFFF}, k: 8'h07, l: 1'b1};
`endif
    exp_q.push_back(w);
    do_start(10'd1, 10'd3, 7'd1);
    feed(16'hFFFF);
    feed(16'h8000);
    feed(16'h7FFF);
    wait_done(4);

    // Reset mid-job, then a fresh 1x1x1 job
    w = '{d: 128'h0004_0003_0002_0001, k: 8'h0F, l: 1'b0};
    exp_q.push_back(w);
    do_start(10'd4, 10'd4, 7'd2);
    for (int i = 1; i <= 5; i++) feed(16'(i));
    rst = 1'b1;
    @(negedge clk_core);
    chk("midrst_outputs", {ifc.result_accept, ifc.out_valid, ifc.out_keep, ifc.out_last, busy, done}, 0);
    chk("midrst_out_data", ifc.out_data, 0);
    chk("midrst_position", {output_row, output_col, output_depth}, 0);
    chk("midrst_queue_empty", exp_q.size(), 0);
    d0 = done_cnt;
    repeat (3) @(posedge clk_core);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk_core);
    chk("midrst_no_done", done_cnt, d0);
    w = '{d: 128'h1234, k: 8'h01, l: 1'b1};
    exp_q.push_back(w);
    do_start(10'd1, 10'd1, 7'd1);
    feed(16'h1234);
    wait_done(d0 + 1);

    // Zero kernel count: immediate done, nothing emitted
    d0 = done_cnt;
    do_start(10'd2, 10'd2, 7'd0);
    @(negedge clk_core);
    chk("zero_cfg_done", done, 1);
    chk("zero_cfg_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_core);
      chk("zero_cfg_quiet", {ifc.out_valid, ifc.result_accept, busy}, 0);
    end
    @(posedge clk_core);
    chk("zero_cfg_done_count", done_cnt, d0 + 1);

    // Start during a busy job is ignored
    expect_job(1, 8, 1, 16'h0A00);
    do_start(10'd1, 10'd8, 7'd1);
    for (int i = 0; i < 4; i++) feed(16'(16'h0A00 + i));
    do_start(10'd3, 10'd5, 7'd2);
    for (int i = 4; i < 8; i++) feed(16'(16'h0A00 + i));
    wait_done(d0 + 2);
    chk("busy_start_depth", output_depth, 1);
    repeat (5) @(posedge clk_core);
    #1;
    chk("busy_start_no_rerun", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
